// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two WIDTH-bit operands through one 4-bit ripple
// slice, least-significant nibble first, with a start/done handshake.
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow,
  output logic             done
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [4:0] nib_sum;
  logic       carry_into_msb;

  // ready is a pure decode of the state register, so it has no input path
  assign ready = (state == IDLE);

  // The single 4-bit slice: current nibble plus the carry held from the last one
  always_comb begin
    a_nib          = a_q[{idx, 2'b00} +: 4];
    b_nib          = b_q[{idx, 2'b00} +: 4];
    nib_sum        = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    carry_into_msb = a_nib[3] ^ b_nib[3] ^ nib_sum[3];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept in IDLE, walk all nibbles in RUN, one DONE cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, per-nibble result write, carry and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx      <= '0;
      s        <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == RUN) && (idx == LAST_IDX);
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= c_in;
            idx      <= '0;
            s        <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          s[{idx, 2'b00} +: 4] <= nib_sum[3:0];
          carry_q              <= nib_sum[4];
          if (idx == LAST_IDX) begin
            idx      <= '0;
            c_out    <= nib_sum[4];
            overflow <= carry_into_msb ^ nib_sum[4];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: table vectors, hand-written corner sequences and a
// random regression, all checked through an expected-result queue.
module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int LATENCY = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             overflow;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ov;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ov;
    int               acc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  int checks     = 0;
  int fails      = 0;
  int cyc        = 0;
  int done_count = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .ready    (ready),
    .s        (s),
    .c_out    (c_out),
    .overflow (overflow),
    .done     (done)
  );

  // Free-running clock and edge counter used to time the done latency
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: full-width add and signed overflow from operand/result signs
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mc, input int acc);
    exp_t e;
    logic [WIDTH:0] full;
    full    = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mc};
    e.s     = full[WIDTH-1:0];
    e.c_out = full[WIDTH];
    e.ov    = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
    e.acc   = acc;
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sum", 32'(s), 32'(e.s));
        checkOutput("c_out", 32'(c_out), 32'(e.c_out));
        checkOutput("overflow", 32'(overflow), 32'(e.ov));
        checkOutput("done_latency", 32'(cyc - e.acc), 32'(LATENCY));
        done_count++;
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      fails++;
      $display("[TB] FAIL ready_timeout: got ready=%b, expected 1 within 20 cycles", ready);
    end
  endtask

  // Present one request, queue its expected result, then scramble the inputs
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                               input logic tc, input logic [WIDTH-1:0] es,
                               input logic ec, input logic eo);
    exp_t e;
    waitReady();
    a     = ta;
    b     = tb_v;
    c_in  = tc;
    start = 1'b1;
    e.s = es; e.c_out = ec; e.ov = eo; e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    c_in  = 1'($urandom);
    checkOutput("ready_low_after_accept", 32'(ready), 32'd0);
  endtask

  task automatic applyVec(input vec_t v);
    applyStimulus(v.a, v.b, v.c_in, v.s, v.c_out, v.ov);
    waitReady();
    checkOutput("sum_held_idle", 32'(s), 32'(v.s));
  endtask

  initial begin
    int last_acc;
    int accepts;
    int done_before;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_s", 32'(s), 32'd0);
    checkOutput("reset_c_out", 32'(c_out), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) begin
      applyVec(vecs[i]);
    end

    // start held high with operands changing every cycle
    $display("[TB] continuous start");
    waitReady();
    last_acc    = -1;
    accepts     = 0;
    done_before = done_count;
    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
      a = ra; b = rb; c_in = rc; start = 1'b1;
      if (ready === 1'b1) begin
        sb.push_back(model(ra, rb, rc, cyc + 1));
        if (last_acc >= 0) begin
          checkOutput("accept_interval", 32'(cyc + 1 - last_acc), 32'(LATENCY + 2));
        end
        last_acc = cyc + 1;
        accepts++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    waitReady();
    repeat (8) @(posedge clk);
    #1;
    checkOutput("done_per_accept", 32'(done_count - done_before), 32'(accepts));

    // reset asserted at E2 of an operation abandons it
    $display("[TB] reset mid-run");
    applyStimulus(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_s", 32'(s), 32'd0);
    checkOutput("abort_c_out", 32'(c_out), 32'd0);
    checkOutput("abort_overflow", 32'(overflow), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    applyVec(vecs[7]);

    $display("[TB] random regression");
    for (int i = 0; i < 1000; i++) begin
      waitReady();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
      begin
        exp_t e;
        e = model(ra, rb, rc, 0);
        applyStimulus(ra, rb, rc, e.s, e.c_out, e.ov);
      end
    end
    waitReady();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("queue_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog so a stuck design still ends the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
